// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-add multiplier controller.
package mult_pkg;

    // Operand width the external add/subtract unit is built for.
    localparam int MULT_WIDTH = 32;

    // Controller states: idle/load, add step, shift step, product ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mult_state_t;

endpackage

// File: rtl/mult_shift_reg.sv
// {X,A,B} register: X is the sign extension, A the product high half and
// running partial sum, B the multiplier that becomes the product low half.
module mult_shift_reg
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_a,
    input  logic             load_b,
    input  logic             load_sum,
    input  logic             shift,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s,
    input  logic             x_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             x_out
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             x_q, x_d;

    // Next-value selection; controls are mutually exclusive in practice,
    // later ones win if the controller ever asserts more than one.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        if (clear_a) begin
            a_d = '0;
            x_d = 1'b0;
        end
        if (load_b) begin
            b_d = b_in;
        end
        if (load_sum) begin
            a_d = s;
            x_d = x_in;
        end
        if (shift) begin
            // Arithmetic shift of {X,A,B}: X replicates into A's top bit.
            a_d = {x_q, a_q[WIDTH-1:1]};
            b_d = {a_q[0], b_q[WIDTH-1:1]};
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign x_out = x_q;

endmodule

// File: rtl/mult_datapath_ctrl.sv
// Signed shift-add multiplier controller. Sequences an external add/subtract
// unit over WIDTH add/shift pairs; the final add subtracts M to account for
// the multiplier's sign bit.
module mult_datapath_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Switches,
    input  logic [WIDTH-1:0] S,
    input  logic             x,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic [WIDTH-1:0] Mval,
    output logic             add_en,
    output logic             sub,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;

    logic clear_a, load_b, load_sum, shift;
    logic last_step;

    assign last_step = (cnt_q == CNT_LAST);

    // Next state, counter, multiplicand capture and datapath controls.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        clear_a  = 1'b0;
        load_b   = 1'b0;
        load_sum = 1'b0;
        shift    = 1'b0;
        add_en   = 1'b0;
        sub      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    m_d     = Switches;
                    clear_a = 1'b1;
                    cnt_d   = '0;
                    state_d = ADD;
                end else if (ClearA_LoadB) begin
                    clear_a = 1'b1;
                    load_b  = 1'b1;
                end
            end
            ADD: begin
                busy     = 1'b1;
                add_en   = Bval[0];
                sub      = Bval[0] & last_step;
                load_sum = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ADD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and multiplicand registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
        end
    end

    mult_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .clk     (Clk),
        .reset   (Reset),
        .clear_a (clear_a),
        .load_b  (load_b),
        .load_sum(load_sum),
        .shift   (shift),
        .b_in    (Switches),
        .s       (S),
        .x_in    (x),
        .a_out   (Aval),
        .b_out   (Bval),
        .x_out   (Xval)
    );

    assign Mval = m_q;

endmodule

// File: tb/tb_mult_datapath_ctrl.sv
// Self-checking bench for mult_datapath_ctrl. The external add/subtract unit
// is modelled here; results are compared against the signed product M*B.
module tb_mult_datapath_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        ClearA_LoadB = 1'b0;
    logic [31:0] Switches = '0;
    logic [31:0] S;
    logic        x;
    logic [31:0] Aval, Bval, Mval;
    logic        Xval, add_en, sub, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;

    mult_datapath_ctrl #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
        .Switches(Switches), .S(S), .x(x),
        .Aval(Aval), .Bval(Bval), .Xval(Xval), .Mval(Mval),
        .add_en(add_en), .sub(sub), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // External 33-bit sign-extended add/subtract unit: A + M, A - M, or A + 0.
    logic signed [32:0] a_ext, op_ext, sum_ext;
    always_comb begin
        a_ext  = {Aval[31], Aval};
        op_ext = {Mval[31], Mval};
        if (!add_en)  op_ext = '0;
        else if (sub) op_ext = -op_ext;
        sum_ext = a_ext + op_ext;
        S = sum_ext[31:0];
        x = sum_ext[32];
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] b);
        logic signed [63:0] ms, bs;
        ms = $signed({{32{m[31]}}, m});
        bs = $signed({{32{b[31]}}, b});
        return 64'(ms * bs);
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b1; Switches = $urandom;
        cycle();
        cycle();
        Run = 1'b0; ClearA_LoadB = 1'b0;
        cycle();
        Reset = 1'b0;
        total_cnt++; if (Aval !== 32'h0) $display("FAIL rst_aval got %h want 0", Aval); else pass_cnt++;
        total_cnt++; if (Bval !== 32'h0) $display("FAIL rst_bval got %h want 0", Bval); else pass_cnt++;
        total_cnt++; if (Mval !== 32'h0) $display("FAIL rst_mval got %h want 0", Mval); else pass_cnt++;
        total_cnt++; if ({Xval, add_en, sub, busy, done} !== 5'b0)
            $display("FAIL rst_flags got x=%b add=%b sub=%b busy=%b done=%b want all 0", Xval, add_en, sub, busy, done);
        else pass_cnt++;
    endtask

    task automatic load_b(input logic [31:0] b);
        ClearA_LoadB = 1'b1; Run = 1'b0; Switches = b;
        cycle();
        ClearA_LoadB = 1'b0;
        total_cnt++; if (Bval !== b) $display("FAIL load_b got %h want %h", Bval, b); else pass_cnt++;
        total_cnt++; if ({Aval, Xval} !== 33'h0 || busy !== 1'b0)
            $display("FAIL load_clear got A=%h X=%b busy=%b want 0", Aval, Xval, busy);
        else pass_cnt++;
    endtask

    // Runs one multiply of m by b_init (already in B). clr_at >= 0 pulses
    // ClearA_LoadB at that cycle of the run; release_run drops Run after DONE.
    task automatic do_mult(input logic [31:0] m, input logic [31:0] b_init,
                           input int clr_at, input bit release_run, input string tag);
        int n, sub_cnt, sub_at, add_cnt, bad;
        logic [63:0] exp;
        exp = ref_prod(m, b_init);
        n = 0; sub_cnt = 0; sub_at = -1; add_cnt = 0; bad = 0;
        Switches = m; Run = 1'b1;
        cycle();
        while (!done && n < 200) begin
            if (sub) begin sub_cnt++; sub_at = n; end
            if (add_en) add_cnt++;
            if ((sub && !add_en) || !busy) bad++;
            ClearA_LoadB = (n == clr_at);
            Switches = $urandom;
            cycle();
            n++;
        end
        ClearA_LoadB = 1'b0;
        total_cnt++; if (n !== 64) $display("FAIL %s latency got %0d want 64", tag, n); else pass_cnt++;
        total_cnt++; if ({Aval, Bval} !== exp)
            $display("FAIL %s product got %h_%h want %h", tag, Aval, Bval, exp);
        else pass_cnt++;
        total_cnt++; if (Xval !== exp[63]) $display("FAIL %s xval got %b want %b", tag, Xval, exp[63]); else pass_cnt++;
        total_cnt++; if (Mval !== m) $display("FAIL %s mval got %h want %h", tag, Mval, m); else pass_cnt++;
        total_cnt++; if (sub_cnt !== int'(b_init[31]) || (b_init[31] && sub_at !== 62))
            $display("FAIL %s sub got count %0d at %0d want count %0d at 62", tag, sub_cnt, sub_at, b_init[31]);
        else pass_cnt++;
        total_cnt++; if (add_cnt !== $countones(b_init))
            $display("FAIL %s add_en got %0d cycles want %0d", tag, add_cnt, $countones(b_init));
        else pass_cnt++;
        total_cnt++; if (bad !== 0) $display("FAIL %s run_flags got %0d bad cycles want 0", tag, bad); else pass_cnt++;
        if (release_run) begin
            Run = 1'b0;
            cycle();
            total_cnt++; if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL %s idle_return got done=%b busy=%b want 0 0", tag, done, busy);
            else pass_cnt++;
            total_cnt++; if ({Aval, Bval, Mval} !== {exp, m})
                $display("FAIL %s idle_hold got %h_%h m=%h want %h m=%h", tag, Aval, Bval, Mval, exp, m);
            else pass_cnt++;
        end
    endtask

    task automatic test_directed();
        load_b(32'd5);
        do_mult(32'd3, 32'd5, -1, 1'b1, "5x3");
        total_cnt++; if ({Aval, Bval, Xval} !== {32'd0, 32'd15, 1'b0})
            $display("FAIL 5x3_exact got %h_%h x=%b want 0_f x=0", Aval, Bval, Xval);
        else pass_cnt++;
        load_b(32'd5);
        do_mult(32'hFFFF_FFFD, 32'd5, -1, 1'b1, "5xm3");
        load_b(32'hFFFF_FFFD);
        do_mult(32'd5, 32'hFFFF_FFFD, -1, 1'b1, "m3x5");
        load_b(32'h8000_0000);
        do_mult(32'h8000_0000, 32'h8000_0000, -1, 1'b1, "min_sq");
        load_b(32'h0);
        do_mult($urandom, 32'h0, -1, 1'b1, "b_zero");
    endtask

    task automatic test_random();
        logic [31:0] b, m;
        for (int i = 0; i < 8; i++) begin
            b = $urandom; m = $urandom;
            load_b(b);
            do_mult(m, b, (i % 2 == 1) ? int'($urandom_range(60)) : -1, 1'b1, "rand");
        end
    endtask

    task automatic test_reset_midrun();
        load_b($urandom | 32'h1);
        Switches = $urandom | 32'h1; Run = 1'b1;
        cycle();
        Run = 1'b0;
        repeat (20) cycle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        total_cnt++; if ({Aval, Bval, Mval, Xval} !== 97'h0)
            $display("FAIL midrst_regs got A=%h B=%h M=%h X=%b want 0", Aval, Bval, Mval, Xval);
        else pass_cnt++;
        cycle();
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_stay got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] b, m1, m2;
        logic [63:0] exp;
        b = $urandom; m1 = $urandom; m2 = $urandom;
        exp = ref_prod(m1, b);
        load_b(b);
        do_mult(m1, b, -1, 1'b0, "hold1");
        for (int i = 0; i < 5; i++) begin
            Switches = $urandom;
            cycle();
            total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || {Aval, Bval} !== exp)
                $display("FAIL hold_done got done=%b busy=%b prod=%h_%h want 1 0 %h", done, busy, Aval, Bval, exp);
            else pass_cnt++;
        end
        Run = 1'b0;
        cycle();
        total_cnt++; if (done !== 1'b0) $display("FAIL hold_release got done=%b want 0", done); else pass_cnt++;
        // B now holds the low half of the previous product.
        do_mult(m2, exp[31:0], -1, 1'b1, "hold2");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
